dmem_sraml_bridge: RTL and testbench
====================================

Name: dmem_sraml_bridge

Overview:
- Data-side bridge between the MEM stage and the SRAM-like data bus.
- Takes the per-access byte enables, aligned write data, size and address produced by the memory-select stage and issues exactly one bus transaction per memory instruction.
- Stalls the pipeline until that transaction completes, then returns the raw read word to the memory-select stage.
- Holds the returned word stable while the pipeline is frozen by other stall sources.

Parameters:
- DW, 32, data/address width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cpu_data_en  in  1  MEM-stage load/store valid; already masked by address-error exceptions
- cpu_data_wen  in  4  byte enables from memory-select stage; nonzero = store, zero = load
- cpu_data_addr  in  32  byte address
- cpu_data_wdata  in  32  lane-aligned write data
- cpu_data_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_flush  in  1  MEM-stage instruction cancelled (exception/eret)
- cpu_longest_stall  in  1  pipeline frozen by any stall source, including this block's d_stall
- cpu_data_rdata  out  32  read word to memory-select stage
- d_stall  out  1  stall request to hazard unit
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  passthrough of cpu_data_size
- data_addr  out  32  passthrough of cpu_data_addr
- data_wdata  out  32  passthrough of cpu_data_wdata
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  32  bus read data

Behaviour:
- States: IDLE, WAIT, DONE.
- Reset, asynchronous on resetn low: state = IDLE; rdata_buf = 0.
- Effect of reset mid-transaction: any pending data_ok is abandoned. The bus side must be reset by the same resetn.

IDLE:
- data_req = cpu_data_en & ~cpu_flush (combinational).
- data_wr = |cpu_data_wen.
- data_addr, data_size and data_wdata are driven straight from the cpu inputs. Inputs stay stable because d_stall holds the pipeline.
- If data_req & data_addr_ok: go to WAIT. Otherwise stay in IDLE and keep data_req high until accepted.

WAIT:
- data_req = 0.
- On data_data_ok: rdata_buf <= data_rdata. Go to DONE if cpu_longest_stall, else IDLE.
- The bus never returns data_ok in the same cycle as the matching addr_ok. Any data_ok seen in IDLE or DONE is ignored.

DONE:
- data_req = 0; no re-issue.
- Go to IDLE when cpu_longest_stall = 0.

d_stall:
- d_stall = (IDLE & cpu_data_en & ~cpu_flush) | (WAIT & ~data_data_ok).
- Stall drops in the same cycle data_ok arrives, so MEM->WB advances at that edge.

cpu_data_rdata:
- Equals data_rdata when in WAIT with data_data_ok; otherwise rdata_buf.
- Zero latency on the completion cycle; held in DONE.

Flush:
- In IDLE, cpu_flush suppresses data_req and d_stall.
- In WAIT, the request is already accepted, so flush does not abort it. The block keeps stalling until data_ok, discards nothing, and returns to IDLE.
- Writes accepted before flush complete on the bus.

Back-to-back accesses:
- A new access may be issued in the cycle after the return to IDLE.
- Exactly one transaction per instruction, guaranteed by the DONE state.

Test Plan:
- Load word: en=1, wen=0, addr=0x8000_0010, size=2; addr_ok in cycle 2, data_ok with rdata=0xDEAD_BEEF in cycle 4 -> data_req high in cycles 1-2 only; d_stall high in cycles 1-3, low in cycle 4; cpu_data_rdata = 0xDEAD_BEEF in cycle 4; state returns to IDLE.
- Store byte: wen=4'b0100, wdata=0x5A5A_5A5A, size=0, addr_ok immediately, data_ok next cycle -> data_wr=1, data_size=0, exactly one req cycle, stall for 1 cycle.
- Completion under external stall: longest_stall=1 throughout a load returning 0x1234_5678 -> block enters DONE; req stays low for 5 stalled cycles; rdata stays 0x1234_5678; returns to IDLE when longest_stall drops; no second req.
- Flush timing:
  - flush=1 with en=1 in IDLE -> data_req=0, d_stall=0.
  - flush asserted in WAIT -> d_stall stays high until data_ok; then IDLE.
- Reset: resetn low for 1 cycle while in WAIT -> immediate IDLE, d_stall=0, data_req=0, cpu_data_rdata=0.
- Back-to-back: two loads in consecutive instructions -> two distinct req bursts, separated by at least the data_ok cycle; each rdata is captured correctly.

Source files
------------

// File: rtl/dmem_sraml_bridge.sv
// Data-side bridge from the MEM stage to an SRAM-like bus: one bus transaction per
// memory instruction, pipeline stall until it completes, read word held across freezes.
module dmem_sraml_bridge #(
  parameter  int unsigned DW  = 32,
  localparam int unsigned BEW = DW / 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           cpu_data_en,
  input  logic [BEW-1:0] cpu_data_wen,
  input  logic [DW-1:0]  cpu_data_addr,
  input  logic [DW-1:0]  cpu_data_wdata,
  input  logic [1:0]     cpu_data_size,
  input  logic           cpu_flush,
  input  logic           cpu_longest_stall,
  output logic [DW-1:0]  cpu_data_rdata,
  output logic           d_stall,
  output logic           data_req,
  output logic           data_wr,
  output logic [1:0]     data_size,
  output logic [DW-1:0]  data_addr,
  output logic [DW-1:0]  data_wdata,
  input  logic           data_addr_ok,
  input  logic           data_data_ok,
  input  logic [DW-1:0]  data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] rdata_buf;
  logic          issue;
  logic          complete;

  assign issue    = cpu_data_en & ~cpu_flush;
  assign complete = (state == WAIT) & data_data_ok;

  // Request fields come straight from the MEM stage; d_stall keeps them stable.
  assign data_wr    = |cpu_data_wen;
  assign data_size  = cpu_data_size;
  assign data_addr  = cpu_data_addr;
  assign data_wdata = cpu_data_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE parks a finished access while the pipeline is frozen so it is never re-issued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue && data_addr_ok) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          state_nxt = cpu_longest_stall ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!cpu_longest_stall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_req       = 1'b0;
    d_stall        = 1'b0;
    cpu_data_rdata = rdata_buf;
    case (state)
      IDLE: begin
        data_req = issue;
        d_stall  = issue;
      end
      WAIT: begin
        d_stall = ~data_data_ok;
        if (data_data_ok) begin
          cpu_data_rdata = data_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  // Completion word is captured once and held until the next access completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf <= '0;
    end else if (complete) begin
      rdata_buf <= data_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_sraml_bridge.sv
// Self-checking bench for dmem_sraml_bridge: directed scenarios plus randomized
// accesses checked against a per-instruction cycle-level expectation.
module tb_dmem_sraml_bridge;

  logic        clk;
  logic        resetn;
  logic        cpu_data_en;
  logic [3:0]  cpu_data_wen;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [1:0]  cpu_data_size;
  logic        cpu_flush;
  logic        cpu_longest_stall;
  logic [31:0] cpu_data_rdata;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_sraml_bridge #(.DW(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cpu_data_en      (cpu_data_en),
    .cpu_data_wen     (cpu_data_wen),
    .cpu_data_addr    (cpu_data_addr),
    .cpu_data_wdata   (cpu_data_wdata),
    .cpu_data_size    (cpu_data_size),
    .cpu_flush        (cpu_flush),
    .cpu_longest_stall(cpu_longest_stall),
    .cpu_data_rdata   (cpu_data_rdata),
    .d_stall          (d_stall),
    .data_req         (data_req),
    .data_wr          (data_wr),
    .data_size        (data_size),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_addr_ok     (data_addr_ok),
    .data_data_ok     (data_data_ok),
    .data_rdata       (data_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic start_access(input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size);
    cpu_data_en    = 1'b1;
    cpu_data_wen   = wen;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    cpu_data_size  = size;
  endtask

  task automatic test_reset();
    data_data_ok = 1'b1;
    data_rdata   = 32'hBAD0_BAD0;
    settle();
    n_cmp++;
    if ({data_req, d_stall} !== 2'b00) begin
      n_fail++; $display("FAIL rst_req_stall: got %b expected 00", {data_req, d_stall});
    end
    n_cmp++;
    if (cpu_data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata: got %h expected 00000000", cpu_data_rdata);
    end
    tick();
    tick();
    resetn       = 1'b1;
    data_data_ok = 1'b0;
    settle();
    n_cmp++;
    if (cpu_data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata_after: got %h expected 00000000", cpu_data_rdata);
    end
    cpu_data_en = 1'b1;
    #1;
    n_cmp++;
    if ({data_req, d_stall} !== 2'b11) begin
      n_fail++; $display("FAIL rst_idle_issue: got %b expected 11", {data_req, d_stall});
    end
    cpu_data_en = 1'b0;
    tick();
  endtask

  task automatic test_load_word();
    logic [1:0] exp_rs [4];
    exp_rs = '{2'b11, 2'b11, 2'b01, 2'b00};
    start_access(4'b0000, 32'h8000_0010, 32'h0, 2'd2);
    for (int c = 0; c < 4; c++) begin
      data_addr_ok      = (c == 1);
      data_data_ok      = (c == 3);
      data_rdata        = (c == 3) ? 32'hDEAD_BEEF : 32'h1111_1111;
      cpu_longest_stall = (c != 3);
      settle();
      n_cmp++;
      if ({data_req, d_stall} !== exp_rs[c]) begin
        n_fail++; $display("FAIL lw_req_stall c%0d: got %b expected %b", c + 1, {data_req, d_stall}, exp_rs[c]);
      end
      if (c == 0) begin
        n_cmp++;
        if ({data_wr, data_size, data_addr} !== {1'b0, 2'd2, 32'h8000_0010}) begin
          n_fail++; $display("FAIL lw_fields: got %b/%0d/%h expected 0/2/80000010", data_wr, data_size, data_addr);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (cpu_data_rdata !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", cpu_data_rdata);
        end
      end
      tick();
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0; cpu_longest_stall = 1'b0;
    settle();
    n_cmp++;
    if ({data_req, d_stall, cpu_data_rdata} !== {2'b11, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL lw_back_idle: got %b %h expected 11 deadbeef", {data_req, d_stall}, cpu_data_rdata);
    end
    cpu_data_en = 1'b0;
    tick();
  endtask

  task automatic test_store_byte();
    int req_cycles = 0;
    int stall_cycles = 0;
    start_access(4'b0100, 32'h0000_1002, 32'h5A5A_5A5A, 2'd0);
    cpu_longest_stall = 1'b1;
    data_addr_ok = 1'b1;
    settle();
    n_cmp++;
    if ({data_wr, data_size, data_wdata} !== {1'b1, 2'd0, 32'h5A5A_5A5A}) begin
      n_fail++; $display("FAIL sb_fields: got %b/%0d/%h expected 1/0/5a5a5a5a", data_wr, data_size, data_wdata);
    end
    req_cycles += int'(data_req); stall_cycles += int'(d_stall);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; cpu_longest_stall = 1'b0;
    settle();
    req_cycles += int'(data_req); stall_cycles += int'(d_stall);
    tick();
    data_data_ok = 1'b0; cpu_data_en = 1'b0;
    settle();
    req_cycles += int'(data_req); stall_cycles += int'(d_stall);
    n_cmp++;
    if (req_cycles != 1 || stall_cycles != 1) begin
      n_fail++; $display("FAIL sb_counts: got req=%0d stall=%0d expected 1/1", req_cycles, stall_cycles);
    end
    tick();
  endtask

  task automatic test_done_stall();
    start_access(4'b0000, 32'h0000_2000, 32'h0, 2'd2);
    cpu_longest_stall = 1'b1;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    settle();
    n_cmp++;
    if ({d_stall, cpu_data_rdata} !== {1'b0, 32'h1234_5678}) begin
      n_fail++; $display("FAIL ds_complete: got %b %h expected 0 12345678", d_stall, cpu_data_rdata);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      cpu_longest_stall = (c < 5);
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata   = $urandom;
      settle();
      n_cmp++;
      if ({data_req, d_stall, cpu_data_rdata} !== {2'b00, 32'h1234_5678}) begin
        n_fail++; $display("FAIL ds_hold c%0d: got %b %h expected 00 12345678", c, {data_req, d_stall}, cpu_data_rdata);
      end
      tick();
    end
    data_data_ok = 1'b0;
    settle();
    n_cmp++;
    if ({data_req, d_stall} !== 2'b11) begin
      n_fail++; $display("FAIL ds_back_idle: got %b expected 11", {data_req, d_stall});
    end
    cpu_data_en = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    start_access(4'b1111, 32'h0000_3000, 32'h0F0F_0F0F, 2'd2);
    cpu_flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_cmp++;
      if ({data_req, d_stall} !== 2'b00) begin
        n_fail++; $display("FAIL fl_idle c%0d: got %b expected 00", c, {data_req, d_stall});
      end
      tick();
    end
    cpu_flush = 1'b0;
    start_access(4'b0000, 32'h0000_3004, 32'h0, 2'd2);
    cpu_longest_stall = 1'b1;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    cpu_flush = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_cmp++;
      if ({data_req, d_stall} !== 2'b01) begin
        n_fail++; $display("FAIL fl_wait c%0d: got %b expected 01", c, {data_req, d_stall});
      end
      tick();
    end
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; cpu_longest_stall = 1'b0;
    settle();
    n_cmp++;
    if ({d_stall, cpu_data_rdata} !== {1'b0, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL fl_wait_done: got %b %h expected 0 cafef00d", d_stall, cpu_data_rdata);
    end
    tick();
    data_data_ok = 1'b0; cpu_flush = 1'b0;
    settle();
    n_cmp++;
    if ({data_req, d_stall} !== 2'b11) begin
      n_fail++; $display("FAIL fl_back_idle: got %b expected 11", {data_req, d_stall});
    end
    cpu_data_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [2];
    int          bursts = 0;
    logic        prev_req = 1'b0;
    words = '{32'hA5A5_0001, 32'h5A5A_0002};
    cpu_longest_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_access(4'b0000, 32'h0000_4000 + 32'(i * 4), 32'h0, 2'd2);
      cpu_longest_stall = 1'b1;
      data_addr_ok = 1'b1;
      settle();
      if (data_req && !prev_req) bursts++;
      prev_req = data_req;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = words[i];
      cpu_longest_stall = 1'b0;
      settle();
      if (data_req && !prev_req) bursts++;
      prev_req = data_req;
      n_cmp++;
      if ({d_stall, cpu_data_rdata} !== {1'b0, words[i]}) begin
        n_fail++; $display("FAIL b2b_rdata%0d: got %b %h expected 0 %h", i, d_stall, cpu_data_rdata, words[i]);
      end
      tick();
      data_data_ok = 1'b0;
    end
    cpu_data_en = 1'b0;
    settle();
    n_cmp++;
    if (bursts != 2 || cpu_data_rdata !== words[1]) begin
      n_fail++; $display("FAIL b2b_bursts: got %0d/%h expected 2/%h", bursts, cpu_data_rdata, words[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_access(4'b0000, 32'h0000_5000, 32'h0, 2'd2);
    cpu_longest_stall = 1'b1;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    #1;
    resetn = 1'b0;
    cpu_data_en = 1'b0;
    cpu_longest_stall = 1'b0;
    #1;
    n_cmp++;
    if ({data_req, d_stall, cpu_data_rdata} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL rm_reset: got %b %h expected 00 00000000", {data_req, d_stall}, cpu_data_rdata);
    end
    tick();
    resetn = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'hAAAA_5555;
    settle();
    n_cmp++;
    if ({d_stall, cpu_data_rdata} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rm_stale_ok: got %b %h expected 0 00000000", d_stall, cpu_data_rdata);
    end
    tick();
    data_data_ok = 1'b0;
    settle();
    n_cmp++;
    if (cpu_data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rm_no_capture: got %h expected 00000000", cpu_data_rdata);
    end
    tick();
  endtask

  // Each instruction: req held until accepted, stall until data_ok, optional frozen tail, idle gap.
  task automatic test_random();
    logic [31:0] held = cpu_data_rdata;
    for (int t = 0; t < 40; t++) begin
      int unsigned a_dly, d_dly, e_dly, gap;
      logic [31:0] addr, wdata, rword;
      logic [3:0]  wen;
      logic [1:0]  size;
      logic        last;
      a_dly = $urandom_range(0, 3);
      d_dly = $urandom_range(1, 4);
      e_dly = $urandom_range(0, 3);
      gap   = $urandom_range(0, 2);
      addr  = $urandom;
      wdata = $urandom;
      rword = $urandom;
      wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      size  = 2'($urandom_range(0, 2));
      start_access(wen, addr, wdata, size);
      cpu_flush = 1'b0;
      cpu_longest_stall = 1'b1;
      for (int k = 0; k <= int'(a_dly); k++) begin
        data_addr_ok = (k == int'(a_dly));
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
        settle();
        n_cmp++;
        if ({data_req, d_stall} !== 2'b11) begin
          n_fail++; $display("FAIL rnd%0d_req k%0d: got %b expected 11", t, k, {data_req, d_stall});
        end
        n_cmp++;
        if ({data_wr, data_size, data_addr, data_wdata} !== {|wen, size, addr, wdata}) begin
          n_fail++; $display("FAIL rnd%0d_fields: got %b/%0d/%h/%h expected %b/%0d/%h/%h", t,
                             data_wr, data_size, data_addr, data_wdata, |wen, size, addr, wdata);
        end
        tick();
      end
      data_addr_ok = 1'b0;
      for (int k = 1; k <= int'(d_dly); k++) begin
        last = (k == int'(d_dly));
        data_data_ok = last;
        data_rdata   = last ? rword : $urandom;
        cpu_flush    = 1'($urandom_range(0, 1));
        cpu_longest_stall = last ? (e_dly != 0) : 1'b1;
        settle();
        n_cmp++;
        if ({data_req, d_stall} !== {1'b0, ~last}) begin
          n_fail++; $display("FAIL rnd%0d_wait k%0d: got %b expected %b", t, k, {data_req, d_stall}, {1'b0, ~last});
        end
        if (last) begin
          n_cmp++;
          if (cpu_data_rdata !== rword) begin
            n_fail++; $display("FAIL rnd%0d_rdata: got %h expected %h", t, cpu_data_rdata, rword);
          end
        end
        tick();
      end
      cpu_flush = 1'b0;
      held = rword;
      for (int k = 1; k <= int'(e_dly) + int'(gap); k++) begin
        cpu_data_en = (k <= int'(e_dly));
        cpu_longest_stall = (k < int'(e_dly));
        data_data_ok = 1'($urandom_range(0, 1));
        data_rdata   = $urandom;
        settle();
        n_cmp++;
        if ({data_req, d_stall, cpu_data_rdata} !== {2'b00, held}) begin
          n_fail++; $display("FAIL rnd%0d_hold k%0d: got %b %h expected 00 %h", t, k, {data_req, d_stall}, cpu_data_rdata, held);
        end
        tick();
      end
      data_data_ok = 1'b0;
      cpu_data_en = 1'b0;
    end
  endtask

  initial begin
    resetn = 1'b0;
    cpu_data_en = 1'b0;
    cpu_data_wen = 4'b0;
    cpu_data_addr = 32'h0;
    cpu_data_wdata = 32'h0;
    cpu_data_size = 2'd0;
    cpu_flush = 1'b0;
    cpu_longest_stall = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = 32'h0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_done_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
